// File: rtl/dmux_1to2.sv
// Registered 1-to-NOUT demultiplexer with out-of-range select flag and
// saturating per-channel delivery counters. All outputs come straight from flops.
module dmux_1to2 #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned NOUT  = 2,
  parameter int unsigned SEL_W = 1,
  parameter int unsigned HOLD  = 0,
  parameter int unsigned CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       a,
  input  logic [SEL_W-1:0]       sel,
  input  logic                   en,
  output logic [NOUT*WIDTH-1:0]  y,
  output logic [NOUT-1:0]        y_valid,
  output logic                   sel_err,
  output logic [NOUT*CNT_W-1:0]  cnt
);

  logic [NOUT*WIDTH-1:0] r_y;
  logic [NOUT-1:0]       r_valid;
  logic                  r_err;
  logic [NOUT*CNT_W-1:0] r_cnt;

  logic [NOUT*WIDTH-1:0] w_y_d;
  logic [NOUT-1:0]       w_valid_d;
  logic                  w_err_d;
  logic [NOUT*CNT_W-1:0] w_cnt_d;
  logic [31:0]           w_sel_ext;
  logic                  w_in_range;

  assign w_sel_ext  = 32'(sel);
  assign w_in_range = (w_sel_ext < NOUT);

  always_comb begin
    // Unselected channels either clear or keep their last value.
    w_y_d     = (HOLD != 0) ? r_y : '0;
    w_valid_d = '0;
    w_cnt_d   = r_cnt;
    w_err_d   = en && !w_in_range;
    for (int unsigned k = 0; k < NOUT; k++) begin
      if (en && w_in_range && (w_sel_ext == k)) begin
        w_y_d[k*WIDTH +: WIDTH] = a;
        w_valid_d[k]            = 1'b1;
        // Saturate rather than wrap.
        if (r_cnt[k*CNT_W +: CNT_W] != {CNT_W{1'b1}}) begin
          w_cnt_d[k*CNT_W +: CNT_W] = r_cnt[k*CNT_W +: CNT_W] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_y     <= '0;
      r_valid <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_y     <= w_y_d;
      r_valid <= w_valid_d;
      r_err   <= w_err_d;
      r_cnt   <= w_cnt_d;
    end
  end

  assign y       = r_y;
  assign y_valid = r_valid;
  assign sel_err = r_err;
  assign cnt     = r_cnt;

endmodule

// File: tb/tb_dmux_1to2.sv
// Directed self-checking bench for dmux_1to2: default, HOLD=1, NOUT=3 and
// CNT_W=2 instances share clock, reset, data and enable.
module tb_dmux_1to2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a = 1'b0;
  logic       en = 1'b0;
  logic       sel1 = 1'b0;
  logic [1:0] sel2 = 2'd0;

  logic [1:0]  y_d, v_d, y_h, v_h, y_s, v_s;
  logic [2:0]  y_o, v_o;
  logic        e_d, e_h, e_o, e_s;
  logic [15:0] c_d, c_h;
  logic [23:0] c_o;
  logic [3:0]  c_s;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmux_1to2 u_def (
    .clk(clk), .rst(rst), .a(a), .sel(sel1), .en(en),
    .y(y_d), .y_valid(v_d), .sel_err(e_d), .cnt(c_d)
  );

  dmux_1to2 #(.HOLD(1)) u_hold (
    .clk(clk), .rst(rst), .a(a), .sel(sel1), .en(en),
    .y(y_h), .y_valid(v_h), .sel_err(e_h), .cnt(c_h)
  );

  dmux_1to2 #(.NOUT(3), .SEL_W(2)) u_oor (
    .clk(clk), .rst(rst), .a(a), .sel(sel2), .en(en),
    .y(y_o), .y_valid(v_o), .sel_err(e_o), .cnt(c_o)
  );

  dmux_1to2 #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .a(a), .sel(sel1), .en(en),
    .y(y_s), .y_valid(v_s), .sel_err(e_s), .cnt(c_s)
  );

  // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; a = 1'b1; sel1 = 1'b1; sel2 = 2'd1; en = 1'b1;
    step();
    step();
    total++;
    if (y_d !== 2'b00) begin bad++; $display("FAIL reset_y: got %b want 00", y_d); end
    total++;
    if (v_d !== 2'b00) begin bad++; $display("FAIL reset_valid: got %b want 00", v_d); end
    total++;
    if (c_d !== 16'h0) begin bad++; $display("FAIL reset_cnt: got %h want 0000", c_d); end
    total++;
    if (e_d !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", e_d); end
    total++;
    if (y_o !== 3'b000 || c_o !== 24'h0) begin
      bad++; $display("FAIL reset_oor: got y=%b cnt=%h want 000/0", y_o, c_o);
    end
    rst = 1'b0;
  endtask

  task automatic test_truth_table();
    logic tv_a   [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic tv_sel [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [1:0] exp_y [4] = '{2'b00, 2'b00, 2'b01, 2'b10};
    logic [1:0] exp_v [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      a = tv_a[i]; sel1 = tv_sel[i]; en = 1'b1;
      step();
      total++;
      if (y_d !== exp_y[i]) begin
        bad++; $display("FAIL truth_y[%0d]: got %b want %b", i, y_d, exp_y[i]);
      end
      total++;
      if (v_d !== exp_v[i]) begin
        bad++; $display("FAIL truth_valid[%0d]: got %b want %b", i, v_d, exp_v[i]);
      end
    end
    total++;
    if (c_d !== {8'd2, 8'd2}) begin
      bad++; $display("FAIL truth_cnt: got %h want 0202", c_d);
    end
  endtask

  task automatic test_enable_low();
    do_reset();
    a = 1'b1; sel1 = 1'b1; en = 1'b1;
    step();
    total++;
    if (y_d !== 2'b10 || y_h !== 2'b10) begin
      bad++; $display("FAIL en_load: got def=%b hold=%b want 10/10", y_d, y_h);
    end
    en = 1'b0;
    step();
    total++;
    if (y_d !== 2'b00 || v_d !== 2'b00) begin
      bad++; $display("FAIL en_low_def: got y=%b v=%b want 00/00", y_d, v_d);
    end
    total++;
    if (c_d !== {8'd1, 8'd0}) begin
      bad++; $display("FAIL en_low_cnt: got %h want 0100", c_d);
    end
    total++;
    if (y_h !== 2'b10 || v_h !== 2'b00) begin
      bad++; $display("FAIL en_low_hold: got y=%b v=%b want 10/00", y_h, v_h);
    end
    sel1 = 1'b0;
    step();
    total++;
    if (y_h !== 2'b10) begin bad++; $display("FAIL hold_idle2: got %b want 10", y_h); end
    en = 1'b1;
    step();
    total++;
    if (y_h !== 2'b11 || c_h !== {8'd1, 8'd1}) begin
      bad++; $display("FAIL hold_other: got y=%b cnt=%h want 11/0101", y_h, c_h);
    end
    total++;
    if (y_d !== 2'b01) begin bad++; $display("FAIL nohold_other: got %b want 01", y_d); end
  endtask

  task automatic test_out_of_range();
    do_reset();
    a = 1'b1; sel2 = 2'd3; en = 1'b1;
    step();
    total++;
    if (e_o !== 1'b1) begin bad++; $display("FAIL oor_err: got %b want 1", e_o); end
    total++;
    if (v_o !== 3'b000 || y_o !== 3'b000 || c_o !== 24'h0) begin
      bad++; $display("FAIL oor_quiet: got v=%b y=%b cnt=%h want 000/000/0", v_o, y_o, c_o);
    end
    sel2 = 2'd2;
    step();
    total++;
    if (e_o !== 1'b0) begin bad++; $display("FAIL oor_err_clear: got %b want 0", e_o); end
    total++;
    if (v_o !== 3'b100 || y_o !== 3'b100 || c_o !== 24'h010000) begin
      bad++; $display("FAIL oor_ch2: got v=%b y=%b cnt=%h want 100/100/010000", v_o, y_o, c_o);
    end
    sel2 = 2'd3; en = 1'b0;
    step();
    total++;
    if (e_o !== 1'b0) begin bad++; $display("FAIL oor_en_low: got %b want 0", e_o); end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_c [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    do_reset();
    a = 1'b1; sel1 = 1'b0; en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (c_s !== {2'd0, exp_c[i]}) begin
        bad++; $display("FAIL sat_cnt[%0d]: got %h want %h", i, c_s, {2'd0, exp_c[i]});
      end
    end
  endtask

  task automatic test_midstream_reset();
    do_reset();
    a = 1'b1; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sel1 = i[0];
      step();
    end
    total++;
    if (c_d !== {8'd2, 8'd2}) begin bad++; $display("FAIL mid_pre: got %h want 0202", c_d); end
    rst = 1'b1; sel1 = 1'b0;
    step();
    total++;
    if (y_d !== 2'b00 || v_d !== 2'b00 || c_d !== 16'h0 || e_d !== 1'b0) begin
      bad++; $display("FAIL mid_rst: got y=%b v=%b cnt=%h err=%b want 0", y_d, v_d, c_d, e_d);
    end
    rst = 1'b0; sel1 = 1'b1;
    step();
    total++;
    if (y_d !== 2'b10 || v_d !== 2'b10 || c_d !== {8'd1, 8'd0}) begin
      bad++; $display("FAIL mid_after: got y=%b v=%b cnt=%h want 10/10/0100", y_d, v_d, c_d);
    end
  endtask

  initial begin
    test_reset();
    test_truth_table();
    test_enable_low();
    test_out_of_range();
    test_saturation();
    test_midstream_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmux_1to2.md
Name: dmux_1to2

Overview:
- Registered 1-to-N demultiplexer. Default configuration is 1-to-2, single-bit data.
- Routes input a to the output channel chosen by sel. Unselected channels drive 0 (or hold, per parameter).
- Used as a generic steering element in datapaths; all outputs are registered for clean timing.
- Also flags out-of-range selects and counts per-channel deliveries.

Parameters:
- WIDTH, 1, data width of a and of each output channel.
- NOUT, 2, number of output channels (2..16).
- SEL_W, 1, width of sel; must be at least clog2(NOUT).
- HOLD, 0, behaviour of unselected channels: 0 = drive 0; 1 = retain last value.
- CNT_W, 8, width of each per-channel delivery counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- a  in  WIDTH  data input.
- sel  in  SEL_W  channel select.
- en  in  1  transfer enable; when 0, no channel is loaded.
- y  out  NOUT*WIDTH  output channels, flattened; channel k occupies bits [k*WIDTH +: WIDTH] (y0 = channel 0, y1 = channel 1).
- y_valid  out  NOUT  one-hot flag: bit k high for one cycle when channel k was loaded with a.
- sel_err  out  1  high for one cycle after a cycle with en=1 and sel >= NOUT.
- cnt  out  NOUT*CNT_W  per-channel delivery counters, flattened like y.

Behaviour:
- Reset: on a rising edge with rst=1, y, y_valid, sel_err and cnt are all set to 0. Reset has priority over every other input.
- Latency: exactly one clock. Values sampled at edge n appear after edge n and are stable until edge n+1.
- Normal transfer, en=1 and sel < NOUT:
  - channel sel <= a; y_valid <= one-hot(sel); sel_err <= 0; cnt[sel] increments.
  - other channels <= 0 when HOLD=0; unchanged when HOLD=1.
- Idle, en=0:
  - y_valid <= 0; sel_err <= 0; cnt unchanged.
  - all channels <= 0 when HOLD=0; unchanged when HOLD=1.
- Out-of-range select, en=1 and sel >= NOUT:
  - no channel is loaded; y_valid <= 0; sel_err <= 1; cnt unchanged.
  - channels behave as in the idle case.
- Transfer of a=0: counts as a delivery. y_valid bit is set and cnt increments even though the data is 0.
- Counters saturate at 2^CNT_W-1 and never wrap.
- The unit has no combinational path from any input to any output.
- Changing sel every cycle is legal. Each cycle is independent and there is no handshake or backpressure.
- Reset asserted mid-stream clears everything on that edge. The first transfer after rst deasserts is accepted normally.

Test Plan:
- Reset: rst=1 for 2 cycles with a=1, sel=1, en=1 -> y=00, y_valid=00, cnt all 0, sel_err=0.
- Truth table, defaults, en=1, one cycle per step:
  - (a=0, sel=0) -> y1=0, y0=0, y_valid=01
  - (a=0, sel=1) -> y1=0, y0=0, y_valid=10
  - (a=1, sel=0) -> y0=1, y1=0
  - (a=1, sel=1) -> y0=0, y1=1
  - final cnt0=2, cnt1=2.
- Enable low: after a=1, sel=1 loads y1=1, set en=0 -> next cycle y=00, y_valid=00, cnt unchanged. Repeat with HOLD=1 -> y1 stays 1.
- Out of range: NOUT=3, SEL_W=2, en=1, sel=3, a=1 -> sel_err=1 for one cycle, y_valid=000, cnt unchanged.
- Saturation: CNT_W=2, drive sel=0, a=1, en=1 for 5 cycles -> cnt0 reaches 3 and stays 3.
- Mid-stream reset: alternate sel 0/1 with a=1, then pulse rst for 1 cycle -> all outputs 0 on that edge; next transfer sel=1, a=1 -> y1=1, cnt1=1.
